// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES decipher controller: round-type
// encodings seen by the round datapath, round counts and FSM state codes.
package aes_pkg;

  typedef enum logic [1:0] {
    RT_INIT  = 2'd0,
    RT_MAIN  = 2'd1,
    RT_FINAL = 2'd2,
    RT_NONE  = 2'd3
  } round_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_MAIN  = 2'd2,
    ST_FINAL = 2'd3
  } ctrl_state_e;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  // Number of rounds for a block; the wide key schedule only counts when supported.
  function automatic logic [3:0] roundsFor(input logic use256);
    return use256 ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

endpackage

// File: rtl/aes_decipher_ctrl.sv
// Iterative AES decipher controller. Holds the 128-bit state register and a
// 4-bit round counter, steps the external round datapath once per cycle
// (INIT, NR-1 x MAIN, FINAL) and presents the plaintext with ready/valid.
module aes_decipher_ctrl
  import aes_pkg::*;
#(
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  input  logic         key_ready,
  input  logic [127:0] block,
  output logic [3:0]   round,
  output logic [1:0]   round_type,
  output logic [127:0] round_state,
  input  logic [127:0] round_new,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid
);

  ctrl_state_e  r_fsm;
  logic [3:0]   r_ctr;
  logic [127:0] r_state;
  logic         r_ready;
  logic         r_valid;

  logic         w_accept;
  logic [3:0]   w_nr;

  // The key length only matters at the moment a block is accepted: it is
  // folded into the counter load, so later changes on keylen cannot disturb
  // a block already in flight.
  assign w_nr     = roundsFor(SUPPORT_256 && keylen);
  assign w_accept = next && r_ready && key_ready;

  // Main sequencer: loads the ciphertext, then replaces the state with the
  // datapath result every cycle while counting the round index down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= ST_IDLE;
      r_ctr   <= 4'd0;
      r_state <= 128'd0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= block;
            r_ctr   <= w_nr;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_fsm   <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_state <= round_new;
          r_ctr   <= r_ctr - 4'd1;
          r_fsm   <= ST_MAIN;
        end
        ST_MAIN: begin
          r_state <= round_new;
          r_ctr   <= r_ctr - 4'd1;
          if (r_ctr == 4'd1) begin
            r_fsm <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_state <= round_new;
          r_ready <= 1'b1;
          r_valid <= 1'b1;
          r_fsm   <= ST_IDLE;
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath controls are decoded from the FSM and counter registers only,
  // so nothing on the start input reaches the round datapath combinationally.
  always_comb begin
    round_type = RT_NONE;
    round      = 4'd0;
    case (r_fsm)
      ST_INIT: begin
        round_type = RT_INIT;
        round      = r_ctr;
      end
      ST_MAIN: begin
        round_type = RT_MAIN;
        round      = r_ctr;
      end
      ST_FINAL: begin
        round_type = RT_FINAL;
        round      = 4'd0;
      end
      default: begin
        round_type = RT_NONE;
        round      = 4'd0;
      end
    endcase
  end

  assign round_state  = r_state;
  assign result       = r_state;
  assign ready        = r_ready;
  assign result_valid = r_valid;

endmodule
